// File: rtl/mul_div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_unit_if
//  Description : Bus between the pipeline controller and the iterative
//                multiply/divide sequencer (operation launch, MTHI/MTLO
//                writes, status and HI/LO readback).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mul_div_unit_if;
   logic        start;
   logic [1:0]  mdOp;
   logic [31:0] mdInput1;
   logic [31:0] mdInput2;
   logic        flush;
   logic        hiWe;
   logic        loWe;
   logic [31:0] writeData;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   // Pipeline controller side
   modport master (
      output start, mdOp, mdInput1, mdInput2, flush, hiWe, loWe, writeData,
      input  busy, done, hi, lo
   );

   // Multiply/divide unit side
   modport slave (
      input  start, mdOp, mdInput1, mdInput2, flush, hiWe, loWe, writeData,
      output busy, done, hi, lo
   );
endinterface
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_unit
//  Description : 32-iteration multiply/divide sequencer (MULT, MULTU, DIV,
//                DIVU) owning the architectural HI/LO registers.
//                Multiply: LSB-first shift-add; divide: MSB-first restoring.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit (
   input  logic           clk,
   input  logic           resetn,
   mul_div_unit_if.slave  md
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   logic [1:0]  state_q,   state_d;
   logic [4:0]  cnt_q,     cnt_d;
   logic [63:0] acc_q,     acc_d;      // {partial hi / remainder, multiplier / dividend}
   logic [31:0] opnd_q,    opnd_d;     // multiplicand or divisor magnitude
   logic        isDiv_q,   isDiv_d;
   logic        divz_q,    divz_d;
   logic        negProd_q, negProd_d;
   logic        negRem_q,  negRem_d;
   logic [31:0] hi_q,      hi_d;
   logic [31:0] lo_q,      lo_d;
   logic        busy_q;
   logic        done_q;

   // Operand sign handling: unsigned ops never see a sign bit
   logic        w_signed;
   logic        w_s1;
   logic        w_s2;
   logic [31:0] w_mag1;
   logic [31:0] w_mag2;
   logic        w_divz;

   assign w_signed = ~md.mdOp[0];
   assign w_s1     = w_signed & md.mdInput1[31];
   assign w_s2     = w_signed & md.mdInput2[31];
   assign w_mag1   = w_s1 ? (~md.mdInput1 + 32'd1) : md.mdInput1;
   assign w_mag2   = w_s2 ? (~md.mdInput2 + 32'd1) : md.mdInput2;
   assign w_divz   = md.mdOp[1] && (md.mdInput2 == 32'd0);

   // One iteration step of each algorithm
   logic [32:0] w_mul_sum;
   logic [32:0] w_div_shift;
   logic [32:0] w_div_diff;
   logic [63:0] w_mul_next;
   logic [63:0] w_div_next;

   assign w_mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
   assign w_mul_next  = {w_mul_sum, acc_q[31:1]};
   assign w_div_shift = {acc_q[63:32], acc_q[31]};
   assign w_div_diff  = w_div_shift - {1'b0, opnd_q};
   // Borrow out means the divisor did not fit: restore and shift in a 0
   assign w_div_next  = w_div_diff[32] ? {w_div_shift[31:0], acc_q[30:0], 1'b0}
                                       : {w_div_diff[31:0],  acc_q[30:0], 1'b1};

   // Sign-corrected results written during FIX
   logic [63:0] w_prod_fix;
   logic [31:0] w_quo_fix;
   logic [31:0] w_rem_fix;

   assign w_prod_fix = negProd_q ? (~acc_q + 64'd1) : acc_q;
   assign w_quo_fix  = negProd_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
   assign w_rem_fix  = negRem_q  ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

   // Sequencer next state: launch, iterate, then hand over to FIX
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      isDiv_d   = isDiv_q;
      divz_d    = divz_q;
      negProd_d = negProd_q;
      negRem_d  = negRem_q;
      case (state_q)
         S_IDLE: begin
            if (md.start && !md.flush) begin
               isDiv_d   = md.mdOp[1];
               negProd_d = w_s1 ^ w_s2;
               negRem_d  = w_s1;
               opnd_d    = w_mag2;
               cnt_d     = 5'd31;
               divz_d    = w_divz;
               if (w_divz) begin
                  // Raw dividend is kept so FIX can return it in HI
                  acc_d   = {32'd0, md.mdInput1};
                  state_d = S_FIX;
               end else begin
                  acc_d   = {32'd0, w_mag1};
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            if (md.flush) begin
               state_d = S_IDLE;
            end else begin
               acc_d = isDiv_q ? w_div_next : w_mul_next;
               if (cnt_q == 5'd0) begin
                  state_d = S_FIX;
               end else begin
                  cnt_d = cnt_q - 5'd1;
               end
            end
         end
         S_FIX:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // HI/LO next value: MTHI/MTLO in any state, FIX result takes priority
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (md.hiWe) hi_d = md.writeData;
      if (md.loWe) lo_d = md.writeData;
      if ((state_q == S_FIX) && !md.flush) begin
         if (divz_q) begin
            hi_d = acc_q[31:0];
            lo_d = 32'hFFFF_FFFF;
         end else if (isDiv_q) begin
            hi_d = w_rem_fix;
            lo_d = w_quo_fix;
         end else begin
            hi_d = w_prod_fix[63:32];
            lo_d = w_prod_fix[31:0];
         end
      end
   end

   // State, datapath and registered status outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         cnt_q     <= 5'd0;
         acc_q     <= 64'd0;
         opnd_q    <= 32'd0;
         isDiv_q   <= 1'b0;
         divz_q    <= 1'b0;
         negProd_q <= 1'b0;
         negRem_q  <= 1'b0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         isDiv_q   <= isDiv_d;
         divz_q    <= divz_d;
         negProd_q <= negProd_d;
         negRem_q  <= negRem_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         busy_q    <= (state_d != S_IDLE);
         done_q    <= (state_q == S_FIX) && !md.flush;
      end
   end

   assign md.busy = busy_q;
   assign md.done = done_q;
   assign md.hi   = hi_q;
   assign md.lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_div_unit
//  Description : Directed-vector bench for mul_div_unit. The driver pushes the
//                expected HI/LO and done cycle into a scoreboard queue; a
//                monitor pops and compares on every done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

   localparam logic [1:0] OP_MULT  = 2'd0;
   localparam logic [1:0] OP_MULTU = 2'd1;
   localparam logic [1:0] OP_DIV   = 2'd2;
   localparam logic [1:0] OP_DIVU  = 2'd3;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sb[$];

   mul_div_unit_if bus ();

   mul_div_unit dut (
      .clk    (clk),
      .resetn (resetn),
      .md     (bus)
   );

   always #5 clk = ~clk;

   // Cycle index: number of rising edges so far
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Called at a falling edge; returns one cycle later with start released
   task automatic issue_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input bit want, input logic [31:0] ehi, input logic [31:0] elo,
                           input int lat);
      exp_t e;
      bus.start    = 1'b1;
      bus.mdOp     = op;
      bus.mdInput1 = a;
      bus.mdInput2 = b;
      if (want) begin
         e.hi  = ehi;
         e.lo  = elo;
         e.cyc = cyc + lat;
         sb.push_back(e);
      end
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Full operation with busy checks at cycle 1, last busy cycle and done cycle
   task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int lat);
      issue_op(op, a, b, 1'b1, ehi, elo, lat);
      chk({name, "_busy_first"}, 64'(bus.busy), 64'd1);
      repeat (lat - 2) @(negedge clk);
      chk({name, "_busy_last"}, 64'(bus.busy), 64'd1);
      @(negedge clk);
      chk({name, "_busy_done"}, 64'(bus.busy), 64'd0);
   endtask

   task automatic monitor_loop();
      exp_t e;
      forever begin
         @(negedge clk);
         if (resetn && bus.done) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_done: got done=1 hi=%h lo=%h expected no done (cyc %0d)",
                        bus.hi, bus.lo, cyc);
            end else begin
               e = sb.pop_front();
               if (bus.hi !== e.hi || bus.lo !== e.lo || cyc != e.cyc) begin
                  n_bad++;
                  $display("FAIL result: got hi=%h lo=%h at cyc %0d expected hi=%h lo=%h at cyc %0d",
                           bus.hi, bus.lo, cyc, e.hi, e.lo, e.cyc);
               end
            end
         end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
            e = sb.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done by cyc %0d expected done at cyc %0d hi=%h lo=%h",
                     cyc, e.cyc, e.hi, e.lo);
         end
      end
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.mdOp      = 2'd0;
      bus.mdInput1  = 32'd0;
      bus.mdInput2  = 32'd0;
      bus.flush     = 1'b0;
      bus.hiWe      = 1'b0;
      bus.loWe      = 1'b0;
      bus.writeData = 32'd0;

      fork
         monitor_loop();
      join_none

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_hi",   64'(bus.hi),   64'd0);
      chk("rst_lo",   64'(bus.lo),   64'd0);
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      // Multiply / divide vectors
      do_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34);
      do_op("mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 34);
      do_op("mult_min",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 34);
      do_op("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
      do_op("div_negd",  OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 34);
      do_op("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 34);
      do_op("divu",      OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        34);
      do_op("divu_z",    OP_DIVU,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 2);
      do_op("div_z",     OP_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 2);

      // MTHI / MTLO, then flush mid-operation
      bus.hiWe = 1'b1; bus.writeData = 32'hA5A5_A5A5;
      @(negedge clk);
      bus.hiWe = 1'b0; bus.loWe = 1'b1; bus.writeData = 32'h5A5A_5A5A;
      chk("mthi", 64'(bus.hi), 64'hA5A5_A5A5);
      @(negedge clk);
      bus.loWe = 1'b0;
      chk("mtlo", 64'(bus.lo), 64'h5A5A_5A5A);
      issue_op(OP_MULTU, 32'd3, 32'd4, 1'b0, 32'd0, 32'd0, 34);
      repeat (9) @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      chk("flush_busy", 64'(bus.busy), 64'd0);
      chk("flush_hi",   64'(bus.hi),   64'hA5A5_A5A5);
      chk("flush_lo",   64'(bus.lo),   64'h5A5A_5A5A);
      repeat (40) @(negedge clk);

      // start and flush together: start is dropped
      bus.start = 1'b1; bus.flush = 1'b1; bus.mdOp = OP_MULTU;
      bus.mdInput1 = 32'd3; bus.mdInput2 = 32'd4;
      @(negedge clk);
      bus.start = 1'b0; bus.flush = 1'b0;
      chk("sf_busy0", 64'(bus.busy), 64'd0);
      repeat (3) @(negedge clk);
      chk("sf_busy3", 64'(bus.busy), 64'd0);
      repeat (36) @(negedge clk);

      // MTHI during CALC is visible, MTLO in the FIX cycle loses to the result
      issue_op(OP_MULTU, 32'd6, 32'd7, 1'b1, 32'd0, 32'd42, 34);
      repeat (4) @(negedge clk);
      bus.hiWe = 1'b1; bus.writeData = 32'h0000_1111;
      @(negedge clk);
      bus.hiWe = 1'b0;
      chk("mthi_calc", 64'(bus.hi), 64'h0000_1111);
      repeat (27) @(negedge clk);
      bus.loWe = 1'b1; bus.writeData = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.loWe = 1'b0;
      repeat (2) @(negedge clk);
      chk("fix_wins_lo", 64'(bus.lo), 64'd42);

      // Asynchronous reset mid-operation
      bus.hiWe = 1'b1; bus.loWe = 1'b1; bus.writeData = 32'h7777_7777;
      @(negedge clk);
      bus.hiWe = 1'b0; bus.loWe = 1'b0;
      issue_op(OP_MULTU, 32'd9, 32'd9, 1'b0, 32'd0, 32'd0, 34);
      repeat (19) @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("arst_busy", 64'(bus.busy), 64'd0);
      chk("arst_done", 64'(bus.done), 64'd0);
      chk("arst_hi",   64'(bus.hi),   64'd0);
      chk("arst_lo",   64'(bus.lo),   64'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);

      // Back-to-back: second start issued in the done cycle of the first
      issue_op(OP_MULTU, 32'd3, 32'd4, 1'b1, 32'd0, 32'd12, 34);
      repeat (33) @(negedge clk);
      chk("b2b_done1", 64'(bus.done), 64'd1);
      issue_op(OP_DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 34);
      chk("b2b_busy", 64'(bus.busy), 64'd1);
      repeat (33) @(negedge clk);
      chk("b2b_done2", 64'(bus.done), 64'd1);

      repeat (5) @(negedge clk);
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
